// File: rtl/mem_stage_pkg.sv
// Shared codes, FSM state type and lane-geometry helpers for the MEM pipeline stage.
package mem_stage_pkg;

   localparam logic [1:0] SzByte  = 2'b00;
   localparam logic [1:0] SzHalf  = 2'b01;
   localparam logic [1:0] SzWord  = 2'b10;
   localparam logic [1:0] SzDword = 2'b11;

   localparam logic [1:0] FwdNone = 2'b00;
   localparam logic [1:0] FwdMem  = 2'b01;
   localparam logic [1:0] FwdWb   = 2'b10;

   typedef enum logic [1:0] {StIdle, StReq, StWaitRd} state_e;

   function automatic int unsigned lanes_of(int unsigned data_w);
      return data_w / 8;
   endfunction

   function automatic int unsigned off_w_of(int unsigned data_w);
      return $clog2(data_w / 8);
   endfunction

   // A 32-bit datapath has no dword access; treat it as a word.
   function automatic logic [1:0] eff_size(logic [1:0] size, int unsigned data_w);
      return (size == SzDword && data_w == 32) ? SzWord : size;
   endfunction

   // Low address bits that must be zero for an access of this size.
   function automatic logic [2:0] size_mask(logic [1:0] size);
      return 3'((4'd1 << size) - 4'd1);
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store replication and byte enables, load extract and extension.
module mem_lane_align
   import mem_stage_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   localparam int unsigned LANES = lanes_of(DATA_W),
   localparam int unsigned OFF_W = off_w_of(DATA_W)
) (
   input  logic [1:0]        st_size,
   input  logic [OFF_W-1:0]  st_off,
   input  logic [DATA_W-1:0] st_data,
   output logic [DATA_W-1:0] st_wdata,
   output logic [LANES-1:0]  st_be,
   input  logic [1:0]        ld_size,
   input  logic [OFF_W-1:0]  ld_off,
   input  logic              ld_sign,
   input  logic [DATA_W-1:0] ld_rdata,
   output logic [DATA_W-1:0] ld_data
);

   logic [DATA_W-1:0]        sh;
   logic [DATA_W-1:0]        top;
   logic signed [DATA_W-1:0] top_s;
   logic [6:0]               gap;

   always_comb begin
      st_be    = '1;
      st_wdata = st_data;
      case (st_size)
         SzByte: begin
            st_be    = LANES'(1) << st_off;
            st_wdata = {LANES{st_data[7:0]}};
         end
         SzHalf: begin
            st_be    = LANES'(3) << st_off;
            st_wdata = {(LANES/2){st_data[15:0]}};
         end
         SzWord: begin
            st_be    = LANES'(15) << st_off;
            st_wdata = {(LANES/4){st_data[31:0]}};
         end
         default: begin
            st_be    = '1;
            st_wdata = st_data;
         end
      endcase
   end

   // Move the selected lanes to the MSBs, then shift back down to extend.
   always_comb begin
      sh    = ld_rdata >> {ld_off, 3'b000};
      gap   = 7'(DATA_W) - (7'd8 << ld_size);
      top   = sh << gap;
      top_s = top;
      if (ld_sign) begin
         ld_data = top_s >>> gap;
      end else begin
         ld_data = top >> gap;
      end
   end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: valid/ready op intake, data-memory access FSM, registered MEM/WB result.
// Define MEM_MISALIGN_TRAP_EN to suppress misaligned accesses and pulse misalign_err.
module mem_access_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned REG_AW = 5,
   localparam int unsigned LANES = lanes_of(DATA_W),
   localparam int unsigned OFF_W = off_w_of(DATA_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] ex_result,
   input  logic [DATA_W-1:0] ex_store_data,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_reg_write,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   input  logic [1:0]        ex_size,
   input  logic              ex_sign_ext,
   input  logic [1:0]        fwd_sel,
   input  logic [DATA_W-1:0] fwd_mem_data,
   input  logic [DATA_W-1:0] fwd_wb_data,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   output logic [LANES-1:0]  dmem_be,
   input  logic              dmem_ready,
   input  logic              dmem_rvalid,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] wb_data,
   output logic [REG_AW-1:0] wb_rd,
   output logic              wb_reg_write,
   output logic              misalign_err
);

   state_e            state_q, state_d;
   logic              accept, is_mem, trap, out_load;
   logic [ADDR_W-1:0] ex_addr;
   logic [OFF_W-1:0]  off, size_msk, off_al;
   logic [1:0]        esz;
   logic [DATA_W-1:0] st_data, st_wdata, ld_data;
   logic [LANES-1:0]  st_be;

   logic [ADDR_W-1:0] addr_q;
   logic              we_q, reg_write_q, sign_q;
   logic [LANES-1:0]  be_q;
   logic [DATA_W-1:0] wdata_q, res_q;
   logic [REG_AW-1:0] rd_q;
   logic [1:0]        size_q;
   logic [OFF_W-1:0]  off_q;

   logic              out_valid_q, out_valid_d, wb_reg_write_q, wb_reg_write_d, err_q, err_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic [REG_AW-1:0] wb_rd_q, wb_rd_d;

   assign ex_addr  = ADDR_W'(ex_result);
   assign is_mem   = ex_mem_read || ex_mem_write;
   assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      esz      = eff_size(ex_size, DATA_W);
      size_msk = OFF_W'(size_mask(esz));
      off      = ex_addr[OFF_W-1:0];
      off_al   = off & ~size_msk;
      unique case (fwd_sel)
         FwdMem:  st_data = fwd_mem_data;
         FwdWb:   st_data = fwd_wb_data;
         default: st_data = ex_store_data;
      endcase
   end

`ifdef MEM_MISALIGN_TRAP_EN
   assign trap = is_mem && |(off & size_msk);
`else
   assign trap = 1'b0;
`endif

   mem_lane_align #(
      .DATA_W(DATA_W)
   ) u_lane_align (
      .st_size (esz),
      .st_off  (off_al),
      .st_data (st_data),
      .st_wdata(st_wdata),
      .st_be   (st_be),
      .ld_size (size_q),
      .ld_off  (off_q),
      .ld_sign (sign_q),
      .ld_rdata(dmem_rdata),
      .ld_data (ld_data)
   );

   always_comb begin
      state_d        = state_q;
      out_load       = 1'b0;
      wb_data_d      = wb_data_q;
      wb_rd_d        = wb_rd_q;
      wb_reg_write_d = wb_reg_write_q;
      err_d          = 1'b0;
      case (state_q)
         StIdle: begin
            if (accept && is_mem && !trap) begin
               state_d = StReq;
            end else if (accept) begin
               out_load       = 1'b1;
               wb_data_d      = ex_result;
               wb_rd_d        = ex_rd;
               wb_reg_write_d = ex_reg_write && !trap;
               err_d          = trap;
            end
         end
         StReq: begin
            if (dmem_ready && we_q) begin
               state_d        = StIdle;
               out_load       = 1'b1;
               wb_data_d      = res_q;
               wb_rd_d        = rd_q;
               wb_reg_write_d = 1'b0;
            end else if (dmem_ready) begin
               state_d = StWaitRd;
            end
         end
         StWaitRd: begin
            if (dmem_rvalid) begin
               state_d        = StIdle;
               out_load       = 1'b1;
               wb_data_d      = ld_data;
               wb_rd_d        = rd_q;
               wb_reg_write_d = reg_write_q;
            end
         end
         default: state_d = StIdle;
      endcase
      out_valid_d = out_load || (out_valid_q && !out_ready);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= StIdle;
         addr_q         <= '0;
         we_q           <= 1'b0;
         be_q           <= '0;
         wdata_q        <= '0;
         res_q          <= '0;
         rd_q           <= '0;
         reg_write_q    <= 1'b0;
         sign_q         <= 1'b0;
         size_q         <= SzByte;
         off_q          <= '0;
         out_valid_q    <= 1'b0;
         wb_data_q      <= '0;
         wb_rd_q        <= '0;
         wb_reg_write_q <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept && is_mem && !trap) begin
            addr_q      <= {ex_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            we_q        <= !ex_mem_read;
            be_q        <= st_be;
            wdata_q     <= st_wdata;
            res_q       <= ex_result;
            rd_q        <= ex_rd;
            reg_write_q <= ex_reg_write;
            sign_q      <= ex_sign_ext;
            size_q      <= esz;
            off_q       <= off_al;
         end
         out_valid_q    <= out_valid_d;
         wb_data_q      <= wb_data_d;
         wb_rd_q        <= wb_rd_d;
         wb_reg_write_q <= wb_reg_write_d;
         err_q          <= err_d;
      end
   end

   assign dmem_req     = (state_q == StReq);
   assign dmem_we      = we_q;
   assign dmem_addr    = addr_q;
   assign dmem_wdata   = wdata_q;
   assign dmem_be      = be_q;
   assign out_valid    = out_valid_q;
   assign wb_data      = wb_data_q;
   assign wb_rd        = wb_rd_q;
   assign wb_reg_write = wb_reg_write_q;
   assign misalign_err = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage; expectations follow MEM_MISALIGN_TRAP_EN if defined.
`timescale 1ns/1ps
module tb_mem_access_stage;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned LANES  = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0, in_ready;
   logic [DATA_W-1:0] ex_result = '0, ex_store_data = '0;
   logic [REG_AW-1:0] ex_rd = '0;
   logic              ex_reg_write = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0;
   logic [1:0]        ex_size = 2'b00, fwd_sel = 2'b00;
   logic              ex_sign_ext = 1'b0;
   logic [DATA_W-1:0] fwd_mem_data = '0, fwd_wb_data = '0;
   logic              dmem_req, dmem_we;
   logic [ADDR_W-1:0] dmem_addr;
   logic [DATA_W-1:0] dmem_wdata;
   logic [LANES-1:0]  dmem_be;
   logic              dmem_ready = 1'b0, dmem_rvalid = 1'b0;
   logic [DATA_W-1:0] dmem_rdata = '0;
   logic              out_valid, out_ready = 1'b1;
   logic [DATA_W-1:0] wb_data;
   logic [REG_AW-1:0] wb_rd;
   logic              wb_reg_write, misalign_err;

   mem_access_stage #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .REG_AW(REG_AW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .ex_result    (ex_result),
      .ex_store_data(ex_store_data),
      .ex_rd        (ex_rd),
      .ex_reg_write (ex_reg_write),
      .ex_mem_read  (ex_mem_read),
      .ex_mem_write (ex_mem_write),
      .ex_size      (ex_size),
      .ex_sign_ext  (ex_sign_ext),
      .fwd_sel      (fwd_sel),
      .fwd_mem_data (fwd_mem_data),
      .fwd_wb_data  (fwd_wb_data),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_wdata   (dmem_wdata),
      .dmem_be      (dmem_be),
      .dmem_ready   (dmem_ready),
      .dmem_rvalid  (dmem_rvalid),
      .dmem_rdata   (dmem_rdata),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .wb_data      (wb_data),
      .wb_rd        (wb_rd),
      .wb_reg_write (wb_reg_write),
      .misalign_err (misalign_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] data;
      logic        chk;
      logic [4:0]  rd;
      logic        we;
      logic        err;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void expect_out(input logic [31:0] d, input logic chk, input logic [4:0] rd,
                                      input logic we, input logic err);
      exp_t e;
      e.data = d;
      e.chk  = chk;
      e.rd   = rd;
      e.we   = we;
      e.err  = err;
      sb.push_back(e);
   endfunction

   // Monitor: every WB handshake pops one expected result.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_out", {63'd0, out_valid}, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            if (mon_e.chk) check("wb_data", wb_data, mon_e.data);
            check("wb_rd", wb_rd, mon_e.rd);
            check("wb_reg_write", wb_reg_write, mon_e.we);
            check("misalign_err", misalign_err, mon_e.err);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called just after a posedge; returns just after the accepting posedge.
   task automatic issue(input logic [31:0] res, input logic [31:0] sdata, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic mw, input logic [1:0] sz,
                        input logic sx, input logic [1:0] fs);
      ex_result     = res;
      ex_store_data = sdata;
      ex_rd         = rd;
      ex_reg_write  = rw;
      ex_mem_read   = mr;
      ex_mem_write  = mw;
      ex_size       = sz;
      ex_sign_ext   = sx;
      fwd_sel       = fs;
      in_valid      = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      check("accept_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic mem_xfer(input int delay, input logic load, input logic [31:0] rdata,
                           input logic [31:0] e_addr, input logic [3:0] e_be,
                           input logic [31:0] e_wdata);
      for (int d = 0; d < delay; d++) begin
         @(negedge clk);
         check("req_held", {63'd0, dmem_req}, 64'd1);
         check("addr_held", dmem_addr, e_addr);
         check("stall_in_ready", {63'd0, in_ready}, 64'd0);
         @(posedge clk);
         #1;
      end
      dmem_ready = 1'b1;
      @(negedge clk);
      check("req", {63'd0, dmem_req}, 64'd1);
      check("addr", dmem_addr, e_addr);
      check("be", dmem_be, e_be);
      check("we", {63'd0, dmem_we}, {63'd0, !load});
      if (!load) check("wdata", dmem_wdata, e_wdata);
      @(posedge clk);
      #1;
      dmem_ready = 1'b0;
      if (load) begin
         dmem_rvalid = 1'b1;
         dmem_rdata  = rdata;
         @(posedge clk);
         #1;
         dmem_rvalid = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst_req", {63'd0, dmem_req}, 64'd0);
      check("rst_we", {63'd0, dmem_we}, 64'd0);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_wb_reg_write", {63'd0, wb_reg_write}, 64'd0);
      check("rst_misalign", {63'd0, misalign_err}, 64'd0);
      check("rst_addr", dmem_addr, 64'd0);
      check("rst_wdata", dmem_wdata, 64'd0);
      check("rst_be", dmem_be, 64'd0);
      check("rst_wb_data", wb_data, 64'd0);
      check("rst_wb_rd", wb_rd, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Back-to-back ALU ops
      expect_out(32'h0000_00A1, 1'b1, 5'd1, 1'b1, 1'b0);
      issue(32'h0000_00A1, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00);
      expect_out(32'h0000_00B2, 1'b1, 5'd2, 1'b0, 1'b0);
      issue(32'h0000_00B2, 32'h0, 5'd2, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00);
      idle(2);

      // WB back-pressure: result held, intake blocked
      out_ready = 1'b0;
      expect_out(32'h0000_1234, 1'b1, 5'd3, 1'b1, 1'b0);
      issue(32'h0000_1234, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00);
      repeat (4) begin
         @(negedge clk);
         check("hold_valid", {63'd0, out_valid}, 64'd1);
         check("hold_data", wb_data, 64'h1234);
         check("hold_in_ready", {63'd0, in_ready}, 64'd0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      idle(1);

      // Stores with each forward select
      fwd_wb_data  = 32'hDEAD_BEEF;
      fwd_mem_data = 32'h0000_00A5;
      expect_out(32'h0, 1'b0, 5'd4, 1'b0, 1'b0);
      issue(32'h0000_0100, 32'h2222_2222, 5'd4, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b10);
      mem_xfer(0, 1'b0, 32'h0, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF);
      expect_out(32'h0, 1'b0, 5'd6, 1'b0, 1'b0);
      issue(32'h0000_0101, 32'h2222_2222, 5'd6, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b01);
      mem_xfer(0, 1'b0, 32'h0, 32'h0000_0100, 4'b0010, 32'hA5A5_A5A5);
      expect_out(32'h0, 1'b0, 5'd7, 1'b0, 1'b0);
      issue(32'h0000_0102, 32'h0000_BEEF, 5'd7, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 2'b11);
      mem_xfer(0, 1'b0, 32'h0, 32'h0000_0100, 4'b1100, 32'hBEEF_BEEF);

      // Loads: byte sign/zero, delayed half, word, unsigned half
      expect_out(32'hFFFF_FF80, 1'b1, 5'd5, 1'b1, 1'b0);
      issue(32'h0000_0103, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 2'b00);
      mem_xfer(0, 1'b1, 32'h80FF_FF7F, 32'h0000_0100, 4'b1000, 32'h0);
      expect_out(32'h0000_0080, 1'b1, 5'd5, 1'b1, 1'b0);
      issue(32'h0000_0103, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
      mem_xfer(0, 1'b1, 32'h80FF_FF7F, 32'h0000_0100, 4'b1000, 32'h0);
      expect_out(32'hFFFF_8001, 1'b1, 5'd8, 1'b1, 1'b0);
      issue(32'h0000_0102, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 2'b00);
      mem_xfer(3, 1'b1, 32'h8001_1234, 32'h0000_0100, 4'b1100, 32'h0);
      expect_out(32'h1234_5678, 1'b1, 5'd9, 1'b1, 1'b0);
      issue(32'h0000_0104, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 2'b00);
      mem_xfer(0, 1'b1, 32'h1234_5678, 32'h0000_0104, 4'hF, 32'h0);
      expect_out(32'h0000_F00D, 1'b1, 5'd10, 1'b1, 1'b0);
      issue(32'h0000_0100, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00);
      mem_xfer(0, 1'b1, 32'h7777_F00D, 32'h0000_0100, 4'b0011, 32'h0);
      idle(2);

      // Reset while waiting for read data: op discarded
      issue(32'h0000_0108, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 2'b00);
      dmem_ready = 1'b1;
      @(posedge clk);
      #1;
      dmem_ready = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_mid_req", {63'd0, dmem_req}, 64'd0);
      check("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Stray rvalid in IDLE must not produce a result
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'hBAD0_BAD0;
      @(posedge clk);
      #1;
      dmem_rvalid = 1'b0;
      @(negedge clk);
      check("stray_rvalid", {63'd0, out_valid}, 64'd0);
      @(posedge clk);
      #1;

      expect_out(32'h0000_0055, 1'b1, 5'd12, 1'b1, 1'b0);
      issue(32'h0000_0055, 32'h0, 5'd12, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00);
      idle(1);

      // Misaligned word store
`ifdef MEM_MISALIGN_TRAP_EN
      expect_out(32'h0, 1'b0, 5'd13, 1'b0, 1'b1);
      issue(32'h0000_0102, 32'h1122_3344, 5'd13, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00);
      repeat (2) begin
         @(negedge clk);
         check("trap_no_req", {63'd0, dmem_req}, 64'd0);
      end
`else
      expect_out(32'h0, 1'b0, 5'd13, 1'b0, 1'b0);
      issue(32'h0000_0102, 32'h1122_3344, 5'd13, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00);
      mem_xfer(0, 1'b0, 32'h0, 32'h0000_0100, 4'hF, 32'h1122_3344);
`endif

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
